mdu_iter: RTL

MDU_ITER -- requirements
Module: mdu_iter

---
 rtl/mdu_pkg.sv | 25 ++
 rtl/mdu_divstep.sv | 21 ++
 rtl/mdu_iter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared op encodings and FSM state type for the iterative mul/div unit.
package mdu_pkg;

  typedef logic [1:0] mdu_op_t;

  localparam mdu_op_t OP_MULT  = 2'b00;
  localparam mdu_op_t OP_MULTU = 2'b01;
  localparam mdu_op_t OP_DIV   = 2'b10;
  localparam mdu_op_t OP_DIVU  = 2'b11;

  typedef logic [1:0] mdu_state_t;

  localparam mdu_state_t S_IDLE = 2'd0;
  localparam mdu_state_t S_CALC = 2'd1;
  localparam mdu_state_t S_FIX  = 2'd2;

  function automatic logic is_div(mdu_op_t op);
    return op[1];
  endfunction

  function automatic logic is_signed_op(mdu_op_t op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division step: shift in a dividend bit, trial-subtract.
module mdu_divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem, bit_in};
  assign diff    = shifted - {1'b0, divisor};
  // rem < divisor keeps diff in range, so the MSB is the borrow
  assign q_bit    = ~diff[WIDTH];
  assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/mdu_iter.sv
// Iterative MIPS-style HI/LO multiply/divide unit, one bit per cycle.
// Optional MTHI/MTLO write port enabled by macro MDU_HILO_WRITE_EN.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
`ifdef MDU_HILO_WRITE_EN
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  import mdu_pkg::*;

  localparam int CW = $clog2(WIDTH);

  mdu_state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;
  logic [WIDTH-1:0] md;
  logic div_op;
  logic neg_res;
  logic neg_rem;
  logic div0;

  logic accept;
  logic a_sgn;
  logic b_sgn;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;

  assign busy   = (state != S_IDLE);
  assign accept = (state == S_IDLE) & start & ~cancel;
  assign a_sgn  = is_signed_op(op) & a[WIDTH-1];
  assign b_sgn  = is_signed_op(op) & b[WIDTH-1];
  assign a_abs  = a_sgn ? -a : a;
  assign b_abs  = b_sgn ? -b : b;

  logic [WIDTH-1:0] ds_rem;
  logic ds_q;

  mdu_divstep #(
    .WIDTH(WIDTH)
  ) u_divstep (
    .rem      (acc),
    .bit_in   (mq[WIDTH-1]),
    .divisor  (md),
    .rem_next (ds_rem),
    .q_bit    (ds_q)
  );

  logic [WIDTH:0] msum;

  assign msum = {1'b0, acc} +
                ({1'b0, md} & {(WIDTH+1){mq[0]}});

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  assign prod   = {acc, mq};
  assign prod_s = neg_res ? -prod : prod;

  always_comb begin
    res_hi = prod_s[2*WIDTH-1:WIDTH];
    res_lo = prod_s[WIDTH-1:0];
    if (div_op) begin
      // x/0: quotient all ones; |a| with a's sign restores a
      res_lo = div0 ? '1 : (neg_res ? -mq : mq);
      res_hi = neg_rem ? -acc : acc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      done    <= 1'b0;
      acc     <= '0;
      mq      <= '0;
      md      <= '0;
      div_op  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (busy && cancel) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        unique case (1'b1)
          (state == S_IDLE): begin
            if (accept) begin
              state   <= S_CALC;
              cnt     <= CW'(WIDTH-1);
              acc     <= '0;
              mq      <= is_div(op) ? a_abs : b_abs;
              md      <= is_div(op) ? b_abs : a_abs;
              div_op  <= is_div(op);
              neg_res <= a_sgn ^ b_sgn;
              neg_rem <= a_sgn;
              div0    <= (b == '0);
            end
          end
          (state == S_CALC): begin
            if (div_op) begin
              acc <= ds_rem;
              mq  <= {mq[WIDTH-2:0], ds_q};
            end else begin
              acc <= msum[WIDTH:1];
              mq  <= {msum[0], mq[WIDTH-1:1]};
            end
            cnt <= cnt - CW'(1);
            if (cnt == '0) begin
              state <= S_FIX;
            end
          end
          (state == S_FIX): begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (state == S_FIX && !cancel) begin
      hi <= res_hi;
      lo <= res_lo;
    end
`ifdef MDU_HILO_WRITE_EN
    else begin
      if (hi_we) begin
        hi <= wdata;
      end
      if (lo_we) begin
        lo <= wdata;
      end
    end
`endif
  end

endmodule
